// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Resolves load-use hazards, EX-stage branch flushes and data-memory wait
// states. Control outputs are combinational from state and inputs; state,
// wait counter, error flag and statistics are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rr1,
  input  logic [4:0]       id_rr2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_running,
  input  logic             ex_rfwr,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wr,
  input  logic             ex_branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             state_o,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_memwait
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              set_terr;
  logic              lu;
  logic              mw;
  logic              ev_loaduse;
  logic              ev_flush;
  logic              ev_memwait;

  // Hazard detection terms
  assign lu = ex_running & ex_rfwr & ex_is_load & (ex_wr != 5'd0) &
              ((id_use_rs1 & (id_rr1 == ex_wr)) | (id_use_rs2 & (id_rr2 == ex_wr)));
  assign mw = mem_req & ~mem_ready;

  assign state_o = state;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state: enter MEMWAIT on a stalled access, leave on ready or timeout
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    set_terr  = 1'b0;
    unique case (state)
      RUN: begin
        if (mw) begin
          state_nxt = MEMWAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
          state_nxt = RUN;
          set_terr  = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Control outputs and statistic events; memory wait outranks branch outranks load-use
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    ev_loaduse    = 1'b0;
    ev_flush      = 1'b0;
    ev_memwait    = 1'b0;
    if (!rst) begin
      if ((state == MEMWAIT) ? ~mem_ready : mw) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
        ev_memwait    = 1'b1;
      end else if (state == RUN && ex_branch) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ev_flush     = 1'b1;
      end else if (state == RUN && lu) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        ev_loaduse   = 1'b1;
      end
    end
  end

  // Sticky timeout flag and saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
      cnt_loaduse <= '0;
      cnt_flush   <= '0;
      cnt_memwait <= '0;
    end else begin
      if (set_terr) timeout_err <= 1'b1;
      if (ev_loaduse && cnt_loaduse != '1) cnt_loaduse <= cnt_loaduse + CNT_W'(1);
      if (ev_flush && cnt_flush != '1) cnt_flush <= cnt_flush + CNT_W'(1);
      if (ev_memwait && cnt_memwait != '1) cnt_memwait <= cnt_memwait + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO   = 15;
  localparam int unsigned CW   = 5;
  localparam longint      SAT  = (64'd1 << CW) - 1;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1101011;
  localparam logic [6:0] C_FLUSH = 7'b0010100;
  localparam logic [6:0] C_LU    = 7'b1100100;

  typedef struct {
    logic       rst;
    logic [4:0] rr1;
    logic [4:0] rr2;
    logic       u1;
    logic       u2;
    logic       run;
    logic       rfwr;
    logic       ld;
    logic [4:0] wr;
    logic       br;
    logic       req;
    logic       rdy;
  } vec_t;

  typedef struct {
    vec_t       in;
    logic [6:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst, id_use_rs1, id_use_rs2, ex_running, ex_rfwr, ex_is_load;
  logic ex_branch, mem_req, mem_ready;
  logic [4:0] id_rr1, id_rr2, ex_wr;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
  logic ex_mem_stall, mem_wb_bubble, state_o, timeout_err;
  logic [CW-1:0] cnt_loaduse, cnt_flush, cnt_memwait;
  logic [6:0] dut_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: waiting flag, unready cycles seen, counters
  bit     m_wait;
  int     m_waited;
  bit     m_terr;
  longint m_lu, m_fl, m_mw;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rr1(id_rr1), .id_rr2(id_rr2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_running(ex_running),
    .ex_rfwr(ex_rfwr), .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_branch(ex_branch),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .state_o(state_o), .timeout_err(timeout_err), .cnt_loaduse(cnt_loaduse),
    .cnt_flush(cnt_flush), .cnt_memwait(cnt_memwait)
  );

  assign dut_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                     id_ex_bubble, ex_mem_stall, mem_wb_bubble};

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                              logic run, logic rfwr, logic ld, logic [4:0] wr,
                              logic br, logic req, logic rdy);
    vec_t v;
    v.rst = r; v.rr1 = a; v.rr2 = b; v.u1 = u1; v.u2 = u2; v.run = run;
    v.rfwr = rfwr; v.ld = ld; v.wr = wr; v.br = br; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A load in EX whose nonzero destination is read by the ID instruction
  function automatic bit model_loaduse(vec_t v);
    bit reads_dest;
    reads_dest = (v.u1 && v.rr1 == v.wr) || (v.u2 && v.rr2 == v.wr);
    return v.run && v.rfwr && v.ld && v.wr != 0 && reads_dest;
  endfunction

  function automatic logic [6:0] model_ctrl(vec_t v);
    if (v.rst) return C_NONE;
    if (m_wait) return v.rdy ? C_NONE : C_STALL;
    if (v.req && !v.rdy) return C_STALL;
    if (v.br) return C_FLUSH;
    if (model_loaduse(v)) return C_LU;
    return C_NONE;
  endfunction

  function automatic longint sat_inc(longint x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  task automatic model_clock(input vec_t v);
    logic [6:0] c;
    c = model_ctrl(v);
    if (v.rst) begin
      m_wait = 0; m_waited = 0; m_terr = 0; m_lu = 0; m_fl = 0; m_mw = 0;
      return;
    end
    if (c == C_STALL) m_mw = sat_inc(m_mw);
    if (c == C_FLUSH) m_fl = sat_inc(m_fl);
    if (c == C_LU)    m_lu = sat_inc(m_lu);
    if (c == C_STALL) begin
      m_waited++;
      // entry cycle plus TO waiting cycles exhaust the budget
      if (m_waited == TO + 1) begin
        m_wait = 0; m_terr = 1;
      end else begin
        m_wait = 1;
      end
    end else begin
      m_wait = 0; m_waited = 0;
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_rr1 = v.rr1; id_rr2 = v.rr2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_running = v.run; ex_rfwr = v.rfwr; ex_is_load = v.ld; ex_wr = v.wr;
    ex_branch = v.br; mem_req = v.req; mem_ready = v.rdy;
  endtask

  // One cycle: drive after negedge, check outputs and counters, then advance model
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk("ctrl", dut_ctrl, model_ctrl(v));
    chk("state_o", state_o, m_wait);
    chk("timeout_err", timeout_err, m_terr);
    chk("cnt_loaduse", cnt_loaduse, m_lu);
    chk("cnt_flush", cnt_flush, m_fl);
    chk("cnt_memwait", cnt_memwait, m_mw);
    model_clock(v);
  endtask

  vec_t idle, rstv, waitv, readyv;
  row_t tbl[11];

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstv   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    waitv  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    readyv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    tbl[0]  = '{mk(0, 5, 1, 1, 1, 1, 1, 1, 5, 0, 0, 0), C_LU};   // lw x5; add x6,x5,x1
    tbl[1]  = '{mk(0, 1, 7, 1, 1, 1, 1, 1, 7, 0, 0, 0), C_LU};   // rs2 match
    tbl[2]  = '{mk(0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0), C_NONE}; // x0 destination
    tbl[3]  = '{mk(0, 5, 1, 1, 1, 1, 1, 0, 5, 0, 0, 0), C_NONE}; // not a load
    tbl[4]  = '{mk(0, 5, 1, 1, 1, 0, 1, 1, 5, 0, 0, 0), C_NONE}; // EX empty
    tbl[5]  = '{mk(0, 5, 1, 1, 1, 1, 0, 1, 5, 0, 0, 0), C_NONE}; // no RF write
    tbl[6]  = '{mk(0, 5, 5, 0, 0, 1, 1, 1, 5, 0, 0, 0), C_NONE}; // operands unused
    tbl[7]  = '{mk(0, 5, 1, 1, 1, 1, 1, 1, 5, 1, 0, 0), C_FLUSH};// branch beats lu
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FLUSH};// branch alone
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_NONE}; // access ready at once
    tbl[10] = '{mk(0, 9, 3, 0, 1, 1, 1, 1, 3, 0, 1, 1), C_LU};   // ready access + lu

    // Initial reset held for two edges
    drive(rstv);
    repeat (2) @(posedge clk);
    model_clock(rstv);
    @(negedge clk);
    drive(idle);
    #1;
    chk("rst_ctrl", dut_ctrl, C_NONE);
    chk("rst_state", state_o, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cnt_lu", cnt_loaduse, 0);
    chk("rst_cnt_fl", cnt_flush, 0);
    chk("rst_cnt_mw", cnt_memwait, 0);

    // Table of single-cycle vectors from RUN
    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d", i), dut_ctrl, tbl[i].exp);
    end
    step(idle);
    chk("tbl_cnt_lu", cnt_loaduse, 3);
    chk("tbl_cnt_fl", cnt_flush, 2);
    chk("tbl_cnt_mw", cnt_memwait, 0);

    // Branch together with load-use counts only the flush
    step(rstv); step(rstv);
    step(tbl[7].in);
    step(idle);
    chk("br_lu_fl", cnt_flush, 1);
    chk("br_lu_lu", cnt_loaduse, 0);

    // Memory wait: three unready cycles then ready
    step(rstv); step(rstv);
    for (int i = 0; i < 3; i++) begin
      step(waitv);
      chk("mw_ctrl", dut_ctrl, C_STALL);
      chk("mw_state", state_o, (i == 0) ? 0 : 1);
    end
    step(mk(0, 5, 1, 1, 1, 1, 1, 1, 5, 1, 1, 1));
    chk("mw_ready_ctrl", dut_ctrl, C_NONE);
    chk("mw_ready_state", state_o, 1);
    step(idle);
    chk("mw_done_state", state_o, 0);
    chk("mw_cnt", cnt_memwait, 3);
    chk("mw_no_flush", cnt_flush, 0);

    // Memory never ready: timeout after MEM_TIMEOUT waiting cycles
    step(rstv); step(rstv);
    for (int i = 0; i <= TO; i++) step(waitv);
    step(idle);
    chk("to_state", state_o, 0);
    chk("to_err", timeout_err, 1);
    chk("to_cnt", cnt_memwait, TO + 1);
    repeat (4) step(idle);
    chk("to_sticky", timeout_err, 1);

    // Reset in the middle of a wait
    step(waitv); step(waitv);
    chk("mid_state", state_o, 1);
    step(rstv);
    chk("mid_rst_ctrl", dut_ctrl, C_NONE);
    step(idle);
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_err", timeout_err, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      vec_t v;
      v = mk(($urandom_range(0, 199) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), 1'($urandom),
             5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4));
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
